// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared types and constants for the SPI responder: FSM state
//                encoding, frame geometry and an address range helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_WDATA = 3'd2,
        ST_RDATA = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    localparam int FRAME_BITS = 16;
    localparam int CMD_BITS   = 8;
    localparam int RW_BIT     = 7;
    localparam int CNT_W      = 5;
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;

    // True when a 7-bit address selects an implemented register.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                           input int num_regs);
        return (int'({25'd0, addr}) < num_regs);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module      : spi_edge_sync
//  Description : Two-flop synchroniser for an asynchronous pin followed by a
//                delay flop that yields single-cycle rise/fall pulses.
//  Ports       : clk      - fabric clock
//                reset    - asynchronous active-high reset
//                async_i  - asynchronous input pin
//                rise_o   - one-cycle pulse on a synchronised 0->1 edge
//                fall_o   - one-cycle pulse on a synchronised 1->0 edge
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_edge_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule
`default_nettype wire

// File: rtl/spi_responder.sv
`default_nettype none
// ============================================================================
//  Module      : spi_responder
//  Description : SPI peripheral (CPOL=1/CPHA=1, MSB first) serving a 16-bit
//                {R/W, addr[6:0], data[7:0]} frame against a byte-wide
//                register file. SPI pins are oversampled on the fabric clock.
//  Ports       : clk, reset             - fabric clock, async active-high reset
//                SPI_CLK/CSN/SDI/SDO    - SPI pins (SDO idles high)
//                host_we/addr/wdata     - local register write port
//                wr_strobe/addr/data    - report of the last SPI write
//                busy                   - frame in progress
//                frame_err              - pulse on a truncated frame
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_responder
    import spi_pkg::*;
#(
    parameter int NUM_REGS = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              SPI_CLK,
    input  logic              SPI_CSN,
    input  logic              SPI_SDI,
    output logic              SPI_SDO,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              frame_err
);

    localparam int c_IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [CNT_W-1:0] c_CMD_LAST  = CNT_W'(CMD_BITS - 1);
    localparam logic [CNT_W-1:0] c_FRAME_LAST = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] c_FRAME_END = CNT_W'(FRAME_BITS);

    // ------------------------------------------------------------------
    // Pin conditioning
    // ------------------------------------------------------------------
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_csn_rise;
    logic w_csn_fall;

    spi_edge_sync #(.RESET_VAL(1'b1)) u_sclk_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (SPI_CLK),
        .rise_o  (w_sclk_rise),
        .fall_o  (w_sclk_fall)
    );

    // CSN resets to the asserted level so that a frame already running when
    // reset is released produces no fall edge and is ignored; the eventual
    // rise lands in IDLE where it is harmless.
    spi_edge_sync #(.RESET_VAL(1'b0)) u_csn_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (SPI_CSN),
        .rise_o  (w_csn_rise),
        .fall_o  (w_csn_fall)
    );

    logic sdi_meta_q;
    logic sdi_sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sdi_meta_q <= 1'b1;
            sdi_sync_q <= 1'b1;
        end else begin
            sdi_meta_q <= SPI_SDI;
            sdi_sync_q <= sdi_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // State and datapath
    // ------------------------------------------------------------------
    state_t              state_q;
    logic [CNT_W-1:0]    bit_cnt_q;
    logic [CMD_BITS-2:0] cmd_sr_q;    // top bit is consumed as it completes
    logic [DATA_W-2:0]   data_sr_q;
    logic [DATA_W-1:0]   shift_q;     // read data snapshot, shifted out MSB first
    logic [ADDR_W-1:0]   addr_q;
    logic                sdo_q;
    logic                wr_strobe_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic                busy_q;
    logic                frame_err_q;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];

    // Shift-register contents including the bit arriving on this rise.
    logic [CMD_BITS-1:0] w_cmd_next;
    logic [DATA_W-1:0]   w_data_next;
    logic [DATA_W-1:0]   w_rd_byte;

    assign w_cmd_next  = {cmd_sr_q, sdi_sync_q};
    assign w_data_next = {data_sr_q, sdi_sync_q};

    always_comb begin
        w_rd_byte = '0;
        if (addr_in_range(w_cmd_next[ADDR_W-1:0], NUM_REGS)) begin
            w_rd_byte = regs_q[w_cmd_next[c_IDX_W-1:0]];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            cmd_sr_q    <= '0;
            data_sr_q   <= '0;
            shift_q     <= '0;
            addr_q      <= '0;
            sdo_q       <= 1'b1;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            wr_strobe_q <= 1'b0;
            frame_err_q <= 1'b0;

            // Host write first so that an SPI write to the same register in
            // the same cycle, assigned later in this block, takes priority.
            if (host_we && addr_in_range(host_addr, NUM_REGS)) begin
                regs_q[host_addr[c_IDX_W-1:0]] <= host_wdata;
            end

            if (w_csn_rise) begin
                if ((state_q != ST_IDLE) && (bit_cnt_q != '0) &&
                    (bit_cnt_q != c_FRAME_END)) begin
                    frame_err_q <= 1'b1;
                end
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
                sdo_q   <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (w_csn_fall) begin
                            bit_cnt_q <= '0;
                            busy_q    <= 1'b1;
                            sdo_q     <= 1'b1;
                            state_q   <= ST_CMD;
                        end
                    end

                    ST_CMD: begin
                        if (w_sclk_rise) begin
                            cmd_sr_q  <= w_cmd_next[CMD_BITS-2:0];
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            if (bit_cnt_q == c_CMD_LAST) begin
                                addr_q <= w_cmd_next[ADDR_W-1:0];
                                if (w_cmd_next[RW_BIT]) begin
                                    shift_q <= w_rd_byte;
                                    state_q <= ST_RDATA;
                                end else begin
                                    state_q <= ST_WDATA;
                                end
                            end
                        end
                    end

                    ST_WDATA: begin
                        if (w_sclk_rise) begin
                            data_sr_q <= w_data_next[DATA_W-2:0];
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            if (bit_cnt_q == c_FRAME_LAST) begin
                                if (addr_in_range(addr_q, NUM_REGS)) begin
                                    regs_q[addr_q[c_IDX_W-1:0]] <= w_data_next;
                                end
                                wr_addr_q   <= addr_q;
                                wr_data_q   <= w_data_next;
                                wr_strobe_q <= 1'b1;
                                state_q     <= ST_DRAIN;
                            end
                        end
                    end

                    ST_RDATA: begin
                        // Master samples on the rise, so present on the fall.
                        if (w_sclk_fall) begin
                            sdo_q   <= shift_q[DATA_W-1];
                            shift_q <= {shift_q[DATA_W-2:0], 1'b0};
                        end
                        if (w_sclk_rise) begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            if (bit_cnt_q == c_FRAME_LAST) begin
                                sdo_q   <= 1'b1;
                                state_q <= ST_DRAIN;
                            end
                        end
                    end

                    ST_DRAIN: begin
                        sdo_q <= 1'b1;
                    end

                    default: begin
                        state_q <= ST_IDLE;
                        sdo_q   <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign SPI_SDO   = sdo_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_responder
//  Description : Self-checking bench for spi_responder. Acts as the SPI
//                master, keeps a register-file model and checks outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_responder;

    localparam int H = 6;   // SPI half period in fabric clocks

    logic       clk = 1'b0;
    logic       reset;
    logic       SPI_CLK;
    logic       SPI_CSN;
    logic       SPI_SDI;
    logic       SPI_SDO;
    logic       host_we;
    logic [6:0] host_addr;
    logic [7:0] host_wdata;
    logic       wr_strobe;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       frame_err;

    spi_responder #(.NUM_REGS(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .SPI_CLK    (SPI_CLK),
        .SPI_CSN    (SPI_CSN),
        .SPI_SDI    (SPI_SDI),
        .SPI_SDO    (SPI_SDO),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .wr_strobe  (wr_strobe),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model of the responder's architectural state.
    logic [7:0] model [16];
    logic [6:0] exp_waddr;
    logic [7:0] exp_wdata;

    int strobe_cnt = 0;
    int err_cnt    = 0;
    bit in_read    = 1'b0;
    bit prev_strobe = 1'b0;
    bit prev_err    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_sdo",       {31'd0, SPI_SDO},   32'd1);
        chk("rst_wr_strobe", {31'd0, wr_strobe}, 32'd0);
        chk("rst_wr_addr",   {25'd0, wr_addr},   32'd0);
        chk("rst_wr_data",   {24'd0, wr_data},   32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    endtask

    // Every cycle: SDO high outside a read data phase, pulses one cycle wide.
    always @(negedge clk) begin
        if (!reset) begin
            if (!in_read) chk("sdo_idle_high", {31'd0, SPI_SDO}, 32'd1);
            if (wr_strobe) begin
                strobe_cnt++;
                chk("wr_strobe_width", {31'd0, prev_strobe}, 32'd0);
            end
            if (frame_err) begin
                err_cnt++;
                chk("frame_err_width", {31'd0, prev_err}, 32'd0);
            end
        end
        prev_strobe = wr_strobe;
        prev_err    = frame_err;
    end

    task automatic host_write(input logic [6:0] a, input logic [7:0] d);
        @(negedge clk);
        host_addr  = a;
        host_wdata = d;
        host_we    = 1'b1;
        if (a < 7'd16) model[a[3:0]] = d;
        @(negedge clk);
        host_we = 1'b0;
    endtask

    // One master transaction of nbits bits. collide: host write to reg 5 in
    // the cycle the responder commits the 16th bit. rst_bit: assert reset
    // before that bit (-1 for none).
    task automatic spi_frame(input logic [15:0] word, input int nbits, input bit collide,
                             input int rst_bit, output logic [7:0] rd);
        bit   is_rd;
        bit   rst_hit;
        int   s0;
        int   e0;
        logic [7:0] exp_rd;
        is_rd   = word[15];
        rst_hit = 1'b0;
        rd      = 8'h00;
        s0      = strobe_cnt;
        e0      = err_cnt;

        @(negedge clk);
        SPI_CSN = 1'b0;
        repeat (H) @(negedge clk);
        chk("busy_in_frame", {31'd0, busy}, 32'd1);

        for (int i = 0; i < nbits; i++) begin
            if (i == rst_bit) begin
                reset = 1'b1;
                #1;
                chk_reset_vals();
                for (int k = 0; k < 16; k++) model[k] = 8'h00;
                exp_waddr = 7'h00;
                exp_wdata = 8'h00;
                rst_hit   = 1'b1;
                @(negedge clk);
                @(negedge clk);
                reset = 1'b0;
                s0 = strobe_cnt;
                e0 = err_cnt;
            end
            if (is_rd && i == 8 && !rst_hit) in_read = 1'b1;
            SPI_CLK = 1'b0;
            SPI_SDI = word[15-i];
            repeat (H) @(negedge clk);
            if (i >= 8) rd[15-i] = SPI_SDO;
            SPI_CLK = 1'b1;
            if (collide && i == 15) begin
                // Pin rise -> 2 sync flops -> commit on the third posedge.
                host_addr  = 7'h05;
                host_wdata = 8'h11;
                host_we    = 1'b1;
                model[5]   = 8'h11;
                repeat (3) @(posedge clk);
                @(negedge clk);
                host_we = 1'b0;
                repeat (H-3) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
        end
        in_read = 1'b0;
        SPI_CSN = 1'b1;
        repeat (H) @(negedge clk);
        chk("busy_after_frame", {31'd0, busy}, 32'd0);

        if (!rst_hit && nbits == 16 && !is_rd) begin
            exp_waddr = word[14:8];
            exp_wdata = word[7:0];
            if (word[14:8] < 7'd16) model[word[11:8]] = word[7:0];
        end
        chk("wr_strobe_count", 32'(strobe_cnt - s0),
            (!rst_hit && nbits == 16 && !is_rd) ? 32'd1 : 32'd0);
        chk("frame_err_count", 32'(err_cnt - e0),
            (!rst_hit && nbits != 16 && nbits != 0) ? 32'd1 : 32'd0);
        chk("wr_addr", {25'd0, wr_addr}, {25'd0, exp_waddr});
        chk("wr_data", {24'd0, wr_data}, {24'd0, exp_wdata});
        if (is_rd && nbits == 16 && !rst_hit) begin
            exp_rd = (word[14:8] < 7'd16) ? model[word[11:8]] : 8'h00;
            chk("read_data_model", {24'd0, rd}, {24'd0, exp_rd});
        end
    endtask

    initial begin
        logic [7:0] rd;
        reset      = 1'b1;
        SPI_CLK    = 1'b1;
        SPI_CSN    = 1'b1;
        SPI_SDI    = 1'b1;
        host_we    = 1'b0;
        host_addr  = 7'h00;
        host_wdata = 8'h00;
        for (int k = 0; k < 16; k++) model[k] = 8'h00;
        exp_waddr = 7'h00;
        exp_wdata = 8'h00;

        repeat (3) @(negedge clk);
        chk_reset_vals();
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Write then read back.
        spi_frame(16'h0A5C, 16, 1'b0, -1, rd);
        chk("lit_wr_addr_0A", {25'd0, wr_addr}, 32'h0A);
        chk("lit_wr_data_5C", {24'd0, wr_data}, 32'h5C);
        spi_frame(16'h8A00, 16, 1'b0, -1, rd);
        chk("lit_read_0A", {24'd0, rd}, 32'h5C);

        // Host-port write, SPI read.
        host_write(7'h03, 8'hC3);
        spi_frame(16'h8300, 16, 1'b0, -1, rd);
        chk("lit_read_03", {24'd0, rd}, 32'hC3);

        // Out-of-range read and write.
        spi_frame(16'hA000, 16, 1'b0, -1, rd);
        chk("lit_read_oor", {24'd0, rd}, 32'h00);
        spi_frame(16'h2077, 16, 1'b0, -1, rd);
        chk("lit_wr_addr_oor", {25'd0, wr_addr}, 32'h20);
        spi_frame(16'hA000, 16, 1'b0, -1, rd);
        chk("lit_read_oor2", {24'd0, rd}, 32'h00);

        // Truncated write frame.
        spi_frame(16'h0411, 10, 1'b0, -1, rd);
        spi_frame(16'h8400, 16, 1'b0, -1, rd);
        chk("lit_read_04_unchanged", {24'd0, rd}, 32'h00);

        // Host and SPI write to the same register in the same cycle.
        spi_frame(16'h0522, 16, 1'b1, -1, rd);
        spi_frame(16'h8500, 16, 1'b0, -1, rd);
        chk("lit_read_05_collide", {24'd0, rd}, 32'h22);

        // Reset in the middle of a frame, then normal operation.
        spi_frame(16'h0277, 16, 1'b0, 5, rd);
        spi_frame(16'h0133, 16, 1'b0, -1, rd);
        chk("lit_wr_data_33", {24'd0, wr_data}, 32'h33);
        spi_frame(16'h8100, 16, 1'b0, -1, rd);
        chk("lit_read_01", {24'd0, rd}, 32'h33);
        spi_frame(16'h8A00, 16, 1'b0, -1, rd);
        chk("lit_read_0A_cleared", {24'd0, rd}, 32'h00);
        spi_frame(16'h8200, 16, 1'b0, -1, rd);
        chk("lit_read_02_dropped", {24'd0, rd}, 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/spi_responder.md
# spi_responder

SPI peripheral-side responder for the 16-bit command/data frame used by our SPI master: CPOL=1/CPHA=1, MSB first, command byte = {R/W, 7-bit address}, then one data byte. It holds a small byte-wide register file that the master writes and reads over SPI, and that local logic can preload and monitor. It sits on the FPGA fabric clock and oversamples the SPI pins; it never uses SPI_CLK as a clock.

## Interface
- NUM_REGS, default 16: number of 8-bit registers. Addresses ≥ NUM_REGS read as 0x00, and writes to them are dropped.
- clk  input  1  fabric clock; must be ≥ 8× the SPI_CLK frequency.
- reset  input  1  asynchronous, active-high reset.
- SPI_CLK  input  1  serial clock from the master; idles high.
- SPI_CSN  input  1  chip select, active low.
- SPI_SDI  input  1  serial data from the master.
- SPI_SDO  output  1  serial data to the master; driven 1 outside the read data phase.
- host_we  input  1  local register write strobe.
- host_addr  input  7  local write address.
- host_wdata  input  8  local write data.
- wr_strobe  output  1  one-cycle pulse when an SPI write frame completes.
- wr_addr  output  7  address of the last completed SPI write.
- wr_data  output  8  data of the last completed SPI write.
- busy  output  1  high while a frame is in progress (CSN low, synchronised).
- frame_err  output  1  one-cycle pulse when CSN rises at a bit count other than 0 or 16.

## Operation
- SPI_CLK, SPI_CSN and SPI_SDI each pass through a 2-FF synchroniser. SPI_CLK and SPI_CSN also go through an edge detector (rise/fall pulses).
- States: IDLE, CMD, WDATA, RDATA, DRAIN.
- IDLE: on a CSN fall, clear bit_cnt (5 bits) and enter CMD.
- CMD: on each SPI_CLK rise, shift SDI into cmd_sr and increment bit_cnt. At bit_cnt = 8:
  - if cmd_sr[7] = 1, latch the shift register with reg[addr] (0x00 if out of range) and go to RDATA;
  - otherwise go to WDATA.
- WDATA: on each SPI_CLK rise, shift SDI into data_sr. At bit_cnt = 16:
  - write data_sr to reg[addr] if addr < NUM_REGS;
  - update wr_addr/wr_data and pulse wr_strobe, even for an out-of-range address;
  - go to DRAIN.
- RDATA: on each SPI_CLK fall, drive SPI_SDO with the next shift-register bit, MSB first. The first fall after the command byte presents bit 7. Increment bit_cnt on each rise; at 16, go to DRAIN.
- DRAIN: ignore further clock edges and hold SPI_SDO = 1.
- A CSN rise in any state returns to IDLE. If bit_cnt ∉ {0, 16}, pulse frame_err and perform no register write.
- Host port: host_we writes host_wdata to reg[host_addr] when in range. If it collides with an SPI write to the same address in the same cycle, the SPI write wins.
- Read data is snapshotted when the command byte completes. Later writes do not alter a read in flight.

## Timing
- Reset values:
  - SPI_SDO = 1; wr_strobe = 0; wr_addr = 0; wr_data = 0; busy = 0; frame_err = 0;
  - all registers 0x00; state IDLE.
- Pin edge to internal rise/fall pulse: 2–3 clk cycles.
- SPI_SDO updates ≤ 3 clk after the SPI_CLK fall at the pin. The ≥ 8× clock ratio guarantees setup before the next rise.
- wr_strobe asserts 1 clk after the 16th rise pulse. The register holds the new value in the same cycle.
- frame_err asserts 1 clk after the CSN rise pulse.
- busy rises 1 clk after the CSN fall pulse and falls 1 clk after the CSN rise pulse.
- A reset asserted mid-frame forces all reset values immediately. The responder then waits in IDLE for the next CSN fall; a frame already in progress is ignored.
- Back-to-back frames need CSN high for ≥ 3 clk.

## Structure
- Package spi_pkg: state_t enum, FRAME_BITS = 16, CMD_BITS = 8, RW_BIT = 7.
- Sub-module spi_edge_sync: 2-FF synchroniser plus rise/fall pulse generation. Instantiate it for SPI_CLK and SPI_CSN; SDI uses the synchroniser only.

## Test plan
- SPI write 0x0A5C → reg[0x0A] = 0x5C; one wr_strobe pulse with wr_addr = 0x0A, wr_data = 0x5C; frame_err stays 0.
- Then SPI read 0x8A00 → SDO shifts out 0x5C MSB first across bits 8–15; SPI_SDO = 1 before and after the read phase.
- host_we addr 0x03, data 0xC3, then SPI read 0x8300 → returns 0xC3. SPI read 0xA000 (addr 0x20 ≥ NUM_REGS) → returns 0x00.
- CSN rises after 10 bits of write frame 0x0411 → reg[0x04] unchanged; no wr_strobe; one frame_err pulse.
- Same-cycle host_we (addr 0x05, 0x11) and SPI write completion (0x0522) → reg[0x05] = 0x22.
- Reset asserted at bit 5 of a frame → all outputs return to reset values. The next full write 0x0133 completes normally.
